// File: rtl/dm_dump_uart.sv
// Data-memory dump engine: on start, reads words FIRST_ADDR..LAST_ADDR and sends each MSB byte first as 8N1 UART frames.
// Optional DM_DUMP_CHECKSUM_EN appends a two's-complement checksum byte after the last word.
module dm_dump_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int FIRST_ADDR   = 0,
  parameter int LAST_ADDR    = 255
) (
  input  logic              sysclk,
  input  logic              cpu_resetn,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              uart_txd,
  output logic              busy,
  output logic              done
);

  localparam logic [15:0]       BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] FIRST_A     = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    TX_START,
    TX_DATA,
    TX_STOP,
    NEXT
`ifdef DM_DUMP_CHECKSUM_EN
    , TX_CSUM
`endif
  } state_t;

  state_t      state;
  logic [31:0] word_reg;
  logic [1:0]  byte_idx;
  logic [2:0]  bit_cnt;
  logic [15:0] baud;
  logic [7:0]  tx_shift;
  logic [7:0]  cur_byte;
`ifdef DM_DUMP_CHECKSUM_EN
  logic [7:0]  csum;
  logic [3:0]  csum_bit;
`endif

  always_comb begin
    cur_byte = word_reg[7:0];
    case (byte_idx)
      2'd0:    cur_byte = word_reg[31:24];
      2'd1:    cur_byte = word_reg[23:16];
      2'd2:    cur_byte = word_reg[15:8];
      default: cur_byte = word_reg[7:0];
    endcase
  end

  // The last stop bit of each word is shortened by one cycle and NEXT fills it,
  // so a word costs exactly 2 + 40*CLKS_PER_BIT cycles with txd held high.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state    <= IDLE;
      rd_en    <= 1'b0;
      rd_addr  <= FIRST_A;
      uart_txd <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_reg <= '0;
      byte_idx <= '0;
      bit_cnt  <= '0;
      baud     <= '0;
      tx_shift <= '0;
`ifdef DM_DUMP_CHECKSUM_EN
      csum     <= '0;
      csum_bit <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          if (start) begin
            state   <= READ;
            rd_addr <= FIRST_A;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef DM_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        READ: begin
          rd_en <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          word_reg <= rd_data;
          byte_idx <= 2'd0;
          uart_txd <= 1'b0;
          baud     <= BAUD_RELOAD;
          state    <= TX_START;
        end
        TX_START: begin
          if (baud == 16'd0) begin
            uart_txd <= cur_byte[0];
            tx_shift <= cur_byte >> 1;
            bit_cnt  <= 3'd0;
            baud     <= BAUD_RELOAD;
            state    <= TX_DATA;
`ifdef DM_DUMP_CHECKSUM_EN
            csum     <= csum + cur_byte;
`endif
          end else begin
            baud <= baud - 16'd1;
          end
        end
        TX_DATA: begin
          if (baud == 16'd0) begin
            baud <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= TX_STOP;
            end else begin
              uart_txd <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        TX_STOP: begin
          if (byte_idx == 2'd3) begin
            if (baud == 16'd1) state <= NEXT;
            else               baud  <= baud - 16'd1;
          end else if (baud == 16'd0) begin
            byte_idx <= byte_idx + 2'd1;
            uart_txd <= 1'b0;
            baud     <= BAUD_RELOAD;
            state    <= TX_START;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        NEXT: begin
          if (rd_addr == LAST_A) begin
`ifdef DM_DUMP_CHECKSUM_EN
            tx_shift <= ~csum + 8'd1;
            csum_bit <= 4'd0;
            uart_txd <= 1'b0;
            baud     <= BAUD_RELOAD;
            state    <= TX_CSUM;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            rd_addr <= rd_addr + 1'b1;
            rd_en   <= 1'b1;
            state   <= READ;
          end
        end
`ifdef DM_DUMP_CHECKSUM_EN
        // Whole checksum frame: csum_bit 0 is start, 1..8 data, 9 stop.
        TX_CSUM: begin
          if (baud == 16'd0) begin
            if (csum_bit == 4'd9) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              baud     <= BAUD_RELOAD;
              csum_bit <= csum_bit + 4'd1;
              if (csum_bit == 4'd8) begin
                uart_txd <= 1'b1;
              end else begin
                uart_txd <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
              end
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_dump_uart.sv
// Bench for dm_dump_uart: three instances (single word, three words, top-of-range) watched by a UART receiver.
module tb_dm_dump_uart;

  localparam int CPB = 4;

  logic sysclk = 1'b0;
  logic cpu_resetn = 1'b0;
  logic start = 1'b0;
  always #5 sysclk = ~sysclk;

  logic [31:0] mem [0:255];

  logic       rd_en_a, rd_en_b, rd_en_c;
  logic [7:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic [31:0] rd_data_a, rd_data_b, rd_data_c;
  logic txd_a, txd_b, txd_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  dm_dump_uart #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .FIRST_ADDR(0), .LAST_ADDR(0)) u_one (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .start(start), .rd_en(rd_en_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .uart_txd(txd_a), .busy(busy_a), .done(done_a));

  dm_dump_uart #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .FIRST_ADDR(0), .LAST_ADDR(2)) u_three (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .start(start), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .uart_txd(txd_b), .busy(busy_b), .done(done_b));

  dm_dump_uart #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .FIRST_ADDR(254), .LAST_ADDR(255)) u_top (
    .sysclk(sysclk), .cpu_resetn(cpu_resetn), .start(start), .rd_en(rd_en_c),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .uart_txd(txd_c), .busy(busy_c), .done(done_c));

  // Read data is only valid the cycle after rd_en; otherwise it is poisoned.
  always @(posedge sysclk) begin
    rd_data_a <= rd_en_a ? mem[rd_addr_a] : 32'hDEAD_BEEF;
    rd_data_b <= rd_en_b ? mem[rd_addr_b] : 32'hDEAD_BEEF;
    rd_data_c <= rd_en_c ? mem[rd_addr_c] : 32'hDEAD_BEEF;
  end

  int assert_count = 0;
  int fail_count = 0;
  int sel = 0;
  logic mon_txd;
  always_comb begin
    mon_txd = txd_c;
    case (sel)
      0:       mon_txd = txd_a;
      1:       mon_txd = txd_b;
      default: mon_txd = txd_c;
    endcase
  end

  logic [7:0] rx_q[$];
  logic [7:0] rd_q_a[$], rd_q_b[$], rd_q_c[$];
  int frame_err = 0;
  int busy_cycles = 0;

  // Receiver samples mid-bit on falling clock edges.
  initial begin
    logic       rx_act;
    int         rx_cnt;
    int         k;
    logic [7:0] rx_sh;
    rx_act = 1'b0;
    rx_cnt = 0;
    rx_sh  = '0;
    forever begin
      @(negedge sysclk);
      if (!cpu_resetn) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (!mon_txd) begin
          rx_act = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          k = rx_cnt / CPB;
          if (k == 0) begin
            if (mon_txd) rx_act = 1'b0;
          end else if (k <= 8) begin
            rx_sh[k-1] = mon_txd;
          end else begin
            if (!mon_txd) frame_err++;
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge sysclk);
      if (rd_en_a) rd_q_a.push_back(rd_addr_a);
      if (rd_en_b) rd_q_b.push_back(rd_addr_b);
      if (rd_en_c) rd_q_c.push_back(rd_addr_c);
      if (busy_a) busy_cycles++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic run_dump(input int which, input int inject_at, input bit check_clear);
    bit got;
    sel = which;
    rx_q.delete();
    rd_q_a.delete();
    rd_q_b.delete();
    rd_q_c.delete();
    frame_err = 0;
    busy_cycles = 0;
    applyStimulus();
    if (check_clear) checkOutput("done_cleared_on_start", done_of(which), 1'b0);
    got = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      @(negedge sysclk);
      start = (cyc == inject_at);
      got = done_of(which);
    end
    start = 1'b0;
    checkOutput("dump_done", got, 1'b1);
    for (int i = 0; i < 4000 && (busy_a | busy_b | busy_c); i++) @(negedge sysclk);
    repeat (4) @(negedge sysclk);
  endtask

  task automatic compare_bytes(input string tag, input logic [7:0] exp_b[$]);
    checkOutput({tag, "_count"}, rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_b[i]);
    checkOutput({tag, "_framing"}, frame_err, 0);
  endtask

  initial begin
    logic [7:0] exp_one[$];
    logic [7:0] exp_three[$];
    logic [7:0] exp_top[$];
    exp_one   = '{8'h00, 8'h00, 8'h03, 8'h15};
    exp_three = '{8'h00, 8'h00, 8'h00, 8'h37, 8'h00, 8'h00, 8'h03, 8'hDB, 8'h00, 8'h00, 8'h00, 8'h61};
    exp_top   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef DM_DUMP_CHECKSUM_EN
    exp_one.push_back(8'hE8);
    exp_three.push_back(8'h8A);
    exp_top.push_back(8'h02);
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_0315;
    mem[254] = 32'hA1B2_C3D4;
    mem[255] = 32'h1234_5678;

    repeat (3) @(negedge sysclk);
    checkOutput("rst_txd", txd_b, 1'b1);
    checkOutput("rst_busy", busy_b, 1'b0);
    checkOutput("rst_done", done_b, 1'b0);
    checkOutput("rst_rd_en", rd_en_b, 1'b0);
    checkOutput("rst_rd_addr", rd_addr_b, 8'd0);
    checkOutput("rst_rd_addr_top", rd_addr_c, 8'd254);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge sysclk);

    $display("[TB] single word dump");
    run_dump(0, -1, 1'b0);
    compare_bytes("one", exp_one);
`ifdef DM_DUMP_CHECKSUM_EN
    checkOutput("one_busy_cycles", busy_cycles, 202);
`else
    checkOutput("one_busy_cycles", busy_cycles, 162);
`endif
    checkOutput("one_reads", rd_q_a.size(), 1);
    checkOutput("one_done_level", done_a, 1'b1);

    $display("[TB] three word dump");
    mem[0] = 32'd55;
    mem[1] = 32'd987;
    mem[2] = 32'd97;
    run_dump(1, -1, 1'b0);
    compare_bytes("three", exp_three);
    checkOutput("three_reads", rd_q_b.size(), 3);
    for (int i = 0; i < rd_q_b.size() && i < 3; i++)
      checkOutput($sformatf("three_rd_addr%0d", i), rd_q_b[i], i);

    $display("[TB] top of address range");
    run_dump(2, -1, 1'b0);
    compare_bytes("top", exp_top);
    checkOutput("top_reads", rd_q_c.size(), 2);
    for (int i = 0; i < rd_q_c.size() && i < 2; i++)
      checkOutput($sformatf("top_rd_addr%0d", i), rd_q_c[i], 254 + i);
    checkOutput("top_done", done_c, 1'b1);

    $display("[TB] start during dump is ignored");
    run_dump(1, 90, 1'b1);
    compare_bytes("inject", exp_three);
    checkOutput("inject_reads", rd_q_b.size(), 3);

    $display("[TB] redump after done");
    run_dump(1, -1, 1'b1);
    compare_bytes("redump", exp_three);

    $display("[TB] reset during byte 1 of word 1");
    sel = 1;
    applyStimulus();
    repeat (220) @(negedge sysclk);
    checkOutput("pre_rst_txd", txd_b, 1'b0);
    checkOutput("pre_rst_addr", rd_addr_b, 8'd1);
    #1 cpu_resetn = 1'b0;
    #1;
    checkOutput("mid_rst_txd", txd_b, 1'b1);
    checkOutput("mid_rst_busy", busy_b, 1'b0);
    checkOutput("mid_rst_done", done_b, 1'b0);
    checkOutput("mid_rst_addr", rd_addr_b, 8'd0);
    repeat (2) @(negedge sysclk);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge sysclk);
    run_dump(1, -1, 1'b0);
    compare_bytes("post_rst", exp_three);
    checkOutput("post_rst_reads", rd_q_b.size(), 3);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dm_dump_uart.md
Name: dm_dump_uart

Overview:
- Post-run readout engine for the pipelined core's data memory; the reader side of the data path the processor writes through its store port.
- When the core retires its halt instruction (op 6'b111111), the block walks a word address range over a synchronous read port.
- Each 32-bit word goes out on a UART TX line as 4 bytes, 8N1, so a host can check results without the OLED.
- Sits beside the data_mem banks at top level and shares their address bus through a dedicated read port.

Parameters:
- CLKS_PER_BIT, 868, sysclk cycles per UART bit (100 MHz / 115200); legal range is >= 2.
- ADDR_W, 8, data-memory word address width.
- FIRST_ADDR, 0, first word address dumped.
- LAST_ADDR, 255, last word address dumped, inclusive; must be >= FIRST_ADDR.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- cpu_resetn  in  1  reset, asynchronous, active-low; clock sysclk.
- start  in  1  single-cycle pulse, driven from (op_w==6'b111111); begins a dump.
- rd_en  out  1  single-cycle read strobe to data memory.
- rd_addr  out  ADDR_W  word address for the read; held stable from rd_en until data capture.
- rd_data  in  32  read data; valid and sampled exactly 1 cycle after rd_en.
- uart_txd  out  1  serial output; idle high.
- busy  out  1  high from start acceptance until the final stop bit ends.
- done  out  1  level; set when a dump completes, cleared on the next accepted start or on reset.

Behaviour:
- Reset values: uart_txd=1, busy=0, done=0, rd_en=0, rd_addr=FIRST_ADDR; FSM enters IDLE and all counters clear.
- FSM states: IDLE, READ, CAPTURE, TX_START, TX_DATA, TX_STOP, NEXT.
- IDLE:
  - start=1 -> READ; addr<=FIRST_ADDR, busy<=1, done<=0.
  - start while busy=1 is ignored, with no restart and no queueing.
- READ: rd_en=1 for exactly one cycle -> CAPTURE.
- CAPTURE: word_reg<=rd_data, byte_idx<=0 -> TX_START. Each memory read costs exactly 2 cycles.
- Byte order: MSB byte first. byte_idx 0 sends word_reg[31:24] and byte_idx 3 sends word_reg[7:0].
- TX_START: txd=0 for CLKS_PER_BIT cycles.
- TX_DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7.
- TX_STOP: txd=1 for CLKS_PER_BIT cycles, then:
  - byte_idx<3: byte_idx+1 -> TX_START.
  - otherwise -> NEXT.
- NEXT:
  - addr==LAST_ADDR: busy<=0, done<=1 -> IDLE.
  - otherwise: addr+1 -> READ.
- Address never wraps, even when LAST_ADDR = 2^ADDR_W-1; the comparison happens before increment.
- Baud counter is a 16-bit down-counter reloaded on every bit boundary, so there is no cumulative drift.
- Timing per word: 2 + 4*10*CLKS_PER_BIT cycles, with no gap between the stop bit and the next start bit in the same word.
- FIRST_ADDR==LAST_ADDR dumps exactly one word.
- start on the same cycle the dump ends (NEXT->IDLE) is ignored; start must arrive while in IDLE.
- Reset asserted mid-frame: uart_txd goes to 1 immediately (asynchronously) and all state returns to reset values. A partial byte is abandoned.
- rd_data is sampled only in CAPTURE; changes at any other time have no effect.

Optional Feature:
- Macro DM_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every transmitted data byte.
  - After the last word, one extra state TX_CSUM sends the two's complement of the sum as a normal 8N1 byte.
  - done rises only after its stop bit.
  - The sum clears on start acceptance.
- Undefined: no checksum logic; the dump ends after the last data byte.

Test Plan:
- CLKS_PER_BIT=4, FIRST=LAST=0, mem[0]=32'h00000315, start pulse -> bytes 00,00,03,15 on txd. Byte 0x15 shows bits 1,0,1,0,1,0,0,0 after the start bit. busy is high for exactly 162 cycles, then done=1.
- FIRST=0, LAST=2, mem={32'd55, 32'd987, 32'd97} -> 12 bytes 00 00 00 37 00 00 03 DB 00 00 00 61. rd_en pulses 3 times with rd_addr 0,1,2.
- LAST_ADDR=255 with ADDR_W=8, FIRST=254 -> exactly 2 words read (addresses 254, 255), no read at 0, done=1.
- start pulsed again mid-dump at byte 2 -> ignored; byte stream identical to the undisturbed run; a later start after done re-dumps and clears done.
- cpu_resetn low during TX_DATA of byte 1 -> txd=1 in the same cycle, busy=0, done=0, rd_addr=FIRST_ADDR. After release, a new start gives a full correct dump.
- With DM_DUMP_CHECKSUM_EN, mem[0]=32'h00000315 -> extra byte 0xE8 (sum 0x18) follows 0x15; without the macro, no extra frame.
